// File: rtl/bp_burst_arbiter_2to1.sv
// Two-master to one-client BP Burst arbiter: round-robin on headers,
// grant locked to the winner until its payload beats have all passed.
module bp_burst_arbiter_2to1 #(
    parameter int          hdr_width_p       = 16,
    parameter int          data_width_p      = 64,
    parameter int          cce_block_width_p = 512,
    parameter logic [15:0] payload_mask_p    = '0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [2*hdr_width_p-1:0] mem_header_i,
    input  logic [1:0]               mem_header_v_i,
    output logic [1:0]               mem_header_ready_o,
    input  logic [2*data_width_p-1:0] mem_data_i,
    input  logic [1:0]               mem_data_v_i,
    output logic [1:0]               mem_data_ready_o,
    output logic [hdr_width_p-1:0]   mem_header_o,
    output logic                     mem_header_v_o,
    input  logic                     mem_header_ready_i,
    output logic [data_width_p-1:0]  mem_data_o,
    output logic                     mem_data_v_o,
    input  logic                     mem_data_ready_i
);

    localparam int beat_shift_lp = $clog2(data_width_p / 8);
    localparam int max_beats_lp  = cce_block_width_p / data_width_p;
    localparam int cnt_w_lp      = $clog2(max_beats_lp + 1);

    localparam logic [0:0] e_ready = 1'b0;
    localparam logic [0:0] e_data  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                prio_q, prio_d;
    logic                hold_q, hold_d;
    logic                sel_q, sel_d;
    logic [cnt_w_lp-1:0] beats_q, beats_d;

    logic                sel_live;
    logic                in_ready, in_data;
    logic                hs_hdr, hs_data;
    logic [3:0]          msg_type;
    logic [2:0]          msg_size;
    logic [31:0]         raw_beats;
    logic [cnt_w_lp-1:0] beats_init;

    always_comb begin
        // Frozen selection keeps the offered header stable until accepted.
        if (hold_q) begin
            sel_live = sel_q;
        end else if (&mem_header_v_i) begin
            sel_live = prio_q;
        end else begin
            sel_live = mem_header_v_i[1];
        end

        in_ready = !reset_i && (state_q == e_ready);
        in_data  = !reset_i && (state_q == e_data);

        mem_header_o = sel_live ? mem_header_i[2*hdr_width_p-1:hdr_width_p]
                                : mem_header_i[hdr_width_p-1:0];
        mem_data_o   = sel_q ? mem_data_i[2*data_width_p-1:data_width_p]
                             : mem_data_i[data_width_p-1:0];

        mem_header_v_o     = in_ready && mem_header_v_i[sel_live];
        mem_header_ready_o = 2'b00;
        if (in_ready && mem_header_ready_i) begin
            mem_header_ready_o[sel_live] = 1'b1;
        end

        mem_data_v_o     = in_data && mem_data_v_i[sel_q];
        mem_data_ready_o = 2'b00;
        if (in_data && mem_data_ready_i) begin
            mem_data_ready_o[sel_q] = 1'b1;
        end

        hs_hdr  = mem_header_v_o && mem_header_ready_i;
        hs_data = mem_data_v_o && mem_data_ready_i;

        msg_type  = mem_header_o[3:0];
        msg_size  = mem_header_o[6:4];
        raw_beats = (32'd1 << msg_size) >> beat_shift_lp;
        if (raw_beats == 32'd0) begin
            beats_init = cnt_w_lp'(1);
        end else if (raw_beats > 32'(max_beats_lp)) begin
            beats_init = cnt_w_lp'(max_beats_lp);
        end else begin
            beats_init = cnt_w_lp'(raw_beats);
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        beats_d = beats_q;

        if (in_ready) begin
            if (hs_hdr) begin
                hold_d = 1'b0;
                if (payload_mask_p[msg_type]) begin
                    state_d = e_data;
                    sel_d   = sel_live;
                    beats_d = beats_init;
                end else begin
                    prio_d = ~sel_live;
                end
            end else if (mem_header_v_o) begin
                hold_d = 1'b1;
                sel_d  = sel_live;
            end
        end

        if (in_data && hs_data) begin
            beats_d = beats_q - cnt_w_lp'(1);
            if (beats_q == cnt_w_lp'(1)) begin
                state_d = e_ready;
                prio_d  = ~sel_q;
                hold_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            prio_q  <= 1'b0;
            hold_q  <= 1'b0;
            sel_q   <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_bp_burst_arbiter_2to1.sv
// Directed vector bench for the 2:1 burst arbiter.
// Header layout: {tag[8:0], size[2:0], msg_type[3:0]}; type 1 carries data.
module tb_bp_burst_arbiter_2to1;

    typedef struct {
        logic        rst;
        logic [1:0]  hv;
        logic [15:0] h0;
        logic [15:0] h1;
        logic        hr;
        logic [1:0]  dv;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        dr;
        logic        e_hv;
        logic [1:0]  e_hr;
        logic [15:0] e_hdr;
        logic        e_dv;
        logic [1:0]  e_dr;
        logic [63:0] e_d;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] mem_header_i;
    logic [1:0]  mem_header_v_i;
    logic [1:0]  mem_header_ready_o;
    logic [127:0] mem_data_i;
    logic [1:0]  mem_data_v_i;
    logic [1:0]  mem_data_ready_o;
    logic [15:0] mem_header_o;
    logic        mem_header_v_o;
    logic        mem_header_ready_i;
    logic [63:0] mem_data_o;
    logic        mem_data_v_o;
    logic        mem_data_ready_i;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    bp_burst_arbiter_2to1 #(
        .hdr_width_p(16),
        .data_width_p(64),
        .cce_block_width_p(512),
        .payload_mask_p(16'h0002)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .mem_header_i(mem_header_i),
        .mem_header_v_i(mem_header_v_i),
        .mem_header_ready_o(mem_header_ready_o),
        .mem_data_i(mem_data_i),
        .mem_data_v_i(mem_data_v_i),
        .mem_data_ready_o(mem_data_ready_o),
        .mem_header_o(mem_header_o),
        .mem_header_v_o(mem_header_v_o),
        .mem_header_ready_i(mem_header_ready_i),
        .mem_data_o(mem_data_o),
        .mem_data_v_o(mem_data_v_o),
        .mem_data_ready_i(mem_data_ready_i)
    );

    function automatic logic [15:0] hdr(logic [8:0] tag, logic [2:0] sz, logic [3:0] t);
        return {tag, sz, t};
    endfunction

    function automatic vec_t mk(
        logic rst, logic [1:0] hv, logic [15:0] h0, logic [15:0] h1, logic hr,
        logic [1:0] dv, logic [63:0] d0, logic [63:0] d1, logic dr,
        logic e_hv, logic [1:0] e_hr, logic [15:0] e_hdr,
        logic e_dv, logic [1:0] e_dr, logic [63:0] e_d);
        vec_t v;
        v.rst = rst; v.hv = hv; v.h0 = h0; v.h1 = h1; v.hr = hr;
        v.dv = dv; v.d0 = d0; v.d1 = d1; v.dr = dr;
        v.e_hv = e_hv; v.e_hr = e_hr; v.e_hdr = e_hdr;
        v.e_dv = e_dv; v.e_dr = e_dr; v.e_d = e_d;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic bad;
        @(posedge clk);
        #1;
        reset_i            = v.rst;
        mem_header_v_i     = v.hv;
        mem_header_i       = {v.h1, v.h0};
        mem_header_ready_i = v.hr;
        mem_data_v_i       = v.dv;
        mem_data_i         = {v.d1, v.d0};
        mem_data_ready_i   = v.dr;
        @(negedge clk);
        n_vec++;
        bad = (mem_header_v_o !== v.e_hv) || (mem_header_ready_o !== v.e_hr)
           || (mem_data_v_o !== v.e_dv) || (mem_data_ready_o !== v.e_dr)
           || (v.e_hv && (mem_header_o !== v.e_hdr))
           || (v.e_dv && (mem_data_o !== v.e_d));
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got hv=%b hr=%b hdr=%h dv=%b dr=%b d=%h, want hv=%b hr=%b hdr=%h dv=%b dr=%b d=%h",
                     tag, mem_header_v_o, mem_header_ready_o, mem_header_o,
                     mem_data_v_o, mem_data_ready_o, mem_data_o,
                     v.e_hv, v.e_hr, v.e_hdr, v.e_dv, v.e_dr, v.e_d);
        end
    endtask

    initial begin
        logic [15:0] r0, r1, w0_64, w1_8, w0_32;
        logic [63:0] junk;
        int b;
        logic dr;

        r0    = hdr(9'h020, 3'd3, 4'd0);
        r1    = hdr(9'h021, 3'd3, 4'd0);
        w0_64 = hdr(9'h011, 3'd6, 4'd1);
        w1_8  = hdr(9'h031, 3'd3, 4'd1);
        w0_32 = hdr(9'h041, 3'd5, 4'd1);
        junk  = 64'hDEAD_BEEF_DEAD_BEEF;

        reset_i = 1'b1;
        mem_header_v_i = '0; mem_header_i = '0; mem_header_ready_i = 1'b0;
        mem_data_v_i = '0; mem_data_i = '0; mem_data_ready_i = 1'b0;

        // reset: everything closed even with traffic offered
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(1, 2'b11, r0, r1, 1, 2'b11, junk, junk, 1, 0, 2'b00, 0, 0, 2'b00, 0));

        // master 0 writes 64B: header then 8 beats, master 1 header blocked meanwhile
        tbl.push_back(mk(0, 2'b01, w0_64, 0, 1, 2'b00, 0, 0, 1, 1, 2'b01, w0_64, 0, 2'b00, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 2'b10, 0, r1, 1, 2'b01, 64'hA000 + 64'(k), junk, 1,
                             0, 2'b00, 0, 1, 2'b01, 64'hA000 + 64'(k)));

        // both reading: prio is 1 after master 0's write, so 1,0,1,0,1
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 2'b11, r0, r1, 1, 2'b00, 0, 0, 0, 1,
                             (k % 2 == 0) ? 2'b10 : 2'b01, (k % 2 == 0) ? r1 : r0, 0, 2'b00, 0));

        // master 1 single-beat write while master 0 pushes data
        tbl.push_back(mk(0, 2'b10, 0, w1_8, 1, 2'b01, junk, 0, 1, 1, 2'b10, w1_8, 0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 1, 2'b01, junk, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 1, 2'b11, junk, 64'hB001, 1, 0, 2'b00, 0, 1, 2'b10, 64'hB001));

        // 4-beat burst, client data ready toggling
        tbl.push_back(mk(0, 2'b01, w0_32, 0, 1, 2'b01, junk, 0, 1, 1, 2'b01, w0_32, 0, 2'b00, 0));
        b = 0;
        for (int i = 0; i < 7; i++) begin
            dr = (i % 2 == 0);
            tbl.push_back(mk(0, 2'b00, 0, 0, 1, 2'b01, 64'hC000 + 64'(b), 0, dr,
                             0, 2'b00, 0, 1, {1'b0, dr}, 64'hC000 + 64'(b)));
            if (dr) b++;
        end
        tbl.push_back(mk(0, 2'b10, 0, r1, 1, 2'b01, junk, 0, 1, 1, 2'b10, r1, 0, 2'b00, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // header stall: master 1 latched, master 0 arriving later cannot steal
        apply(mk(0, 2'b10, 0, r1, 0, 2'b00, 0, 0, 0, 1, 2'b00, r1, 0, 2'b00, 0), "hold_c1");
        apply(mk(0, 2'b11, r0, r1, 0, 2'b00, 0, 0, 0, 1, 2'b00, r1, 0, 2'b00, 0), "hold_c2");
        apply(mk(0, 2'b11, r0, r1, 0, 2'b00, 0, 0, 0, 1, 2'b00, r1, 0, 2'b00, 0), "hold_c3");
        apply(mk(0, 2'b11, r0, r1, 1, 2'b00, 0, 0, 0, 1, 2'b10, r1, 0, 2'b00, 0), "hold_acc");
        apply(mk(0, 2'b11, r0, r1, 1, 2'b00, 0, 0, 0, 1, 2'b01, r0, 0, 2'b00, 0), "hold_next");

        // reset after beat 2 of 8; prio is 1 going in
        apply(mk(0, 2'b01, w0_64, 0, 1, 2'b00, 0, 0, 1, 1, 2'b01, w0_64, 0, 2'b00, 0), "rst_hdr");
        apply(mk(0, 2'b00, 0, 0, 1, 2'b01, 64'hD000, 0, 1, 0, 2'b00, 0, 1, 2'b01, 64'hD000), "rst_b0");
        apply(mk(0, 2'b00, 0, 0, 1, 2'b01, 64'hD001, 0, 1, 0, 2'b00, 0, 1, 2'b01, 64'hD001), "rst_b1");
        apply(mk(1, 2'b11, r0, r1, 1, 2'b11, junk, junk, 1, 0, 2'b00, 0, 0, 2'b00, 0), "rst_mid");
        apply(mk(0, 2'b11, r0, r1, 1, 2'b01, junk, 0, 1, 1, 2'b01, r0, 0, 2'b00, 0), "rst_rd0");
        apply(mk(0, 2'b11, r0, r1, 1, 2'b00, 0, 0, 1, 1, 2'b10, r1, 0, 2'b00, 0), "rst_rd1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
